// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: assembles big-endian words from a byte
// stream and writes them from address 0, holding the CPU in reset until loaded.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  // Largest accepted word count is the full memory depth.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [WORD_W-9:0]   asm_q, asm_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [WORD_W-1:0]   im_wdata_q, im_wdata_d;
  logic                cpu_rst_q, done_q, err_q;

  logic                xfer;
  logic [15:0]         hdr_n;
  logic [16:0]         wc_next;

  assign in_ready = rst && ((state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                            (state_q == S_DATA));
  assign xfer     = in_valid && in_ready;
  assign hdr_n    = {n_q[15:8], in_data};
  assign wc_next  = 17'(word_cnt_q) + 17'd1;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    case (state_q)
      S_HDR_HI: begin
        if (xfer) begin
          n_d[15:8] = in_data;
          state_d   = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          n_d[7:0] = in_data;
          if (hdr_n == 16'd0)
            state_d = S_DONE;
          else if ({1'b0, hdr_n} > CAP)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d      = {asm_q[WORD_W-17:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Latch the write beat here so address/data are registered in WRITE.
          if (byte_cnt_q == 2'd3) begin
            state_d    = S_WRITE;
            im_addr_d  = word_cnt_q[ADDR_W-1:0];
            im_wdata_d = {asm_q, in_data};
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        state_d    = (wc_next == {1'b0, n_q}) ? S_DONE : S_DATA;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR_HI;
          n_d        = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      default: state_d = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HDR_HI;
      n_q        <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      // Status flags follow the next state so they toggle only on DONE/ERR entry or exit.
      cpu_rst_q  <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
    end
  end

  assign im_we    = (state_q == S_WRITE);
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams programs and compares the captured
// instruction-memory writes and status outputs with hand-computed values.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int n_pass = 0;
  int n_total = 0;
  int rdy_viol = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] prog[$];

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && im_we === 1'b1) begin
      wr_addr_q.push_back(32'(im_addr));
      wr_data_q.push_back(im_wdata);
      if (in_ready !== 1'b0) rdy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    if (stall) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic load_prog(input bit stall, input bit detail);
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(prog.size());
    send_byte(n[15:8], stall);
    send_byte(n[7:0], stall);
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], stall);
      if (detail) begin
        chk("we_after_4th_byte", 32'(im_we), 32'd1);
        chk("ready_low_in_write", 32'(in_ready), 32'd0);
      end
    end
    if (n != 16'd0) begin
      @(posedge clk);
      #1;
      chk("done_after_last_write", 32'(done), 32'd1);
      chk("cpu_rst_released", 32'(cpu_rst), 32'd0);
      chk("we_low_in_done", 32'(im_we), 32'd0);
    end
  endtask

  task automatic check_writes(input bit detail);
    int errs = 0;
    chk("write_count", 32'(wr_addr_q.size()), 32'(prog.size()));
    for (int i = 0; i < wr_addr_q.size() && i < prog.size(); i++) begin
      if (detail) begin
        chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], 32'(i));
        chk($sformatf("wr_data[%0d]", i), wr_data_q[i], prog[i]);
      end else if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== prog[i]) begin
        errs++;
      end
    end
    if (!detail) chk("write_mismatch_count", 32'(errs), 32'd0);
  endtask

  initial begin
    // Reset values while rst is held low
    #12;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Two-word stream, continuous valid
    clear_writes();
    prog = '{32'h20100200, 32'h2011000C};
    load_prog(1'b0, 1'b1);
    check_writes(1'b1);

    // Same stream with a gap before every byte
    pulse_start();
    chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_ready", 32'(in_ready), 32'd1);
    clear_writes();
    load_prog(1'b1, 1'b1);
    check_writes(1'b1);

    // Zero-length program
    pulse_start();
    clear_writes();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_cpu_rst", 32'(cpu_rst), 32'd0);
    repeat (2) @(negedge clk);
    chk("n0_no_writes", 32'(wr_addr_q.size()), 32'd0);

    // Oversized header is rejected; bytes offered in ERR are not consumed
    pulse_start();
    clear_writes();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("err_flag", 32'(err), 32'd1);
    chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("err_ready", 32'(in_ready), 32'd0);
    chk("err_done", 32'(done), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("err_hold", 32'(err), 32'd1);
    chk("err_no_writes", 32'(wr_addr_q.size()), 32'd0);
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);
    prog = '{32'hDEADBEEF};
    load_prog(1'b0, 1'b1);
    check_writes(1'b1);

    // Partial load, start ignored mid-stream, then asynchronous reset
    pulse_start();
    clear_writes();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_start();
    chk("start_ignored_ready", 32'(in_ready), 32'd1);
    chk("start_ignored_done", 32'(done), 32'd0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    chk("partial_write_data", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hFFFFFFFF, 32'h11223344);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_im_we", 32'(im_we), 32'd0);
    chk("abort_im_wdata", im_wdata, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_writes();
    prog = '{32'hCAFEBABE};
    load_prog(1'b0, 1'b1);
    check_writes(1'b1);

    // 27-word program, then reload one word over it
    pulse_start();
    clear_writes();
    prog.delete();
    for (int i = 0; i < 27; i++) prog.push_back(32'h01000093 + 32'(i) * 32'h00100000);
    load_prog(1'b0, 1'b0);
    check_writes(1'b0);
    pulse_start();
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_done_clr", 32'(done), 32'd0);
    clear_writes();
    prog = '{32'h00000013};
    load_prog(1'b0, 1'b1);
    check_writes(1'b1);

    // Full-depth program
    pulse_start();
    clear_writes();
    prog.delete();
    for (int i = 0; i < 1024; i++) prog.push_back((32'(i) * 32'h9E3779B9) ^ 32'(i));
    load_prog(1'b0, 1'b0);
    check_writes(1'b0);
    chk("full_last_addr", wr_addr_q.size() > 0 ? wr_addr_q[$] : 32'hFFFFFFFF, 32'd1023);

    chk("ready_low_during_writes", 32'(rdy_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words to consecutive instruction-memory word addresses from 0, holding the CPU in reset until the whole program is loaded.
- Replaces backdoor preloading of instruction memory, so programs such as the sort routine can be loaded through real hardware.

Parameters:
ADDR_W, 10, instruction-memory word-address width; capacity is 2**ADDR_W words
WORD_W, 32, instruction word width; fixed at 32, must not be overridden

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; restarts a load from DONE or ERR, ignored in other states
in_valid  input  1  byte-stream valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte; transfer occurs when in_valid && in_ready at the clock edge
im_we  output  1  instruction-memory write enable, one-cycle pulse per word
im_addr  output  ADDR_W  instruction-memory word address
im_wdata  output  32  instruction word
cpu_rst  output  1  active-high reset to CPU_SingleCycle; held high while loading
done  output  1  program loaded, CPU running
err  output  1  header rejected

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: state=HDR_HI, cpu_rst=1, in_ready=0 during reset, im_we=0, im_addr=0, im_wdata=0, done=0, err=0.
  - Internal: byte counter=0, word counter=0, N=0.
- Stream format:
  - Two header bytes give the 16-bit word count N, MSB first.
  - Then N*4 data bytes; each word is sent MSB byte first.
- States:
  - HDR_HI: in_ready=1; on transfer, N[15:8]<=in_data, go to HDR_LO.
  - HDR_LO: in_ready=1; on transfer, N[7:0]<=in_data. Next state:
    - DONE if the full N equals 0;
    - ERR if N > 2**ADDR_W;
    - otherwise DATA.
  - DATA: in_ready=1; each transfer shifts the byte into the low end of the 32-bit assembly register, and the byte counter increments mod 4. On the 4th byte go to WRITE.
  - WRITE: in_ready=0 for exactly one cycle; im_we=1, im_addr=word counter, im_wdata=assembled word. Word counter increments on leaving WRITE. Next state is DONE if the incremented count equals N, else DATA.
  - DONE: cpu_rst=0, done=1, in_ready=0; start goes to HDR_HI.
  - ERR: cpu_rst=1, err=1, in_ready=0, no writes; start goes to HDR_HI.
- Restart via start:
  - Takes effect at the next edge.
  - Clears done, err, and all counters; cpu_rst=1 from that edge onward.
- Timing and throughput:
  - im_we rises on the edge after the 4th byte's handshake.
  - Peak throughput is 4 bytes per 5 cycles.
  - in_valid gaps stall without corrupting state.
  - in_data is sampled only on handshake.
- Output stability: im_addr and im_wdata hold their last value outside WRITE; im_we is 0 outside WRITE.
- cpu_rst and done change only on state transitions into or out of DONE, so they are glitch-free registered outputs.
- Boundary cases:
  - N = 2**ADDR_W: accepted; the last write uses address 2**ADDR_W-1. The word counter must be ADDR_W+1 bits wide so the completion compare does not wrap.
  - start asserted outside DONE/ERR: no effect.
  - Bytes offered while in_ready=0: not consumed; the source must hold them.
  - rst asserted mid-load: immediate abort; partially written memory is left as is; the load restarts at HDR_HI after rst deasserts.

Test Plan:
- Stream 00 02 20 10 02 00 20 11 00 0C, in_valid held high:
  - Two im_we pulses: addr0=0x20100200, addr1=0x2011000C.
  - in_ready low in each WRITE cycle.
  - done=1 and cpu_rst=0 one cycle after the 2nd write.
- Same stream with in_valid low every other cycle: identical writes and data; completion is delayed only by the stall cycles.
- Header 00 00: no im_we; done=1 on the edge after HDR_LO.
- Header 04 01 (N=1025, ADDR_W=10): err=1, cpu_rst stays 1, in_ready=0. Then pulse start and send a valid 1-word stream: err clears and done=1.
- Send header 00 03 plus 6 data bytes, then pulse rst low:
  - Outputs return to reset values immediately.
  - After release, a fresh 1-word stream writes addr0 correctly.
- Load the 27-word sort program, then pulse start and send a 1-word stream:
  - cpu_rst re-asserts on the edge after start.
  - addr0 is rewritten.
  - done returns after 1 write.
